// File: rtl/cur_blk_loader_if.sv
// Memory read bus between the current-block loader and the frame store.
//   mem_req      : read request (master -> slave)
//   mem_addr     : read address in 64-bit words (master -> slave)
//   mem_gnt      : request accepted when mem_req && mem_gnt (slave -> master)
//   mem_rd_valid : read data valid, in request order (slave -> master)
//   mem_rd_data  : 8 pixels, pixel 0 in [63:56] (slave -> master)
interface cur_blk_loader_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rd_valid;
    logic [63:0]       mem_rd_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/cur_blk_loader.sv
// Current-block loader: fetches a 16x16 pixel block (32 words of 64 bits)
// from the frame store, buffers it, then streams it to the current-block
// register file as one contiguous 32-cycle write burst.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : one-cycle load request, taken only when idle
//   blk_x, blk_y   : block column/row in 16-pixel units, captured on start
//   mem            : memory read bus (cur_blk_loader_if.master)
//   rf_we, rf_data : register file write port (rf_data is 0 when rf_we is 0)
//   busy           : high whenever the loader is not idle
//   done           : one-cycle pulse when the load completes
//   blk_sum        : (CUR_BLK_LOADER_SUM_EN only) sum of all 256 pixels,
//                    valid from the done cycle until the next start
//
// Build option: define CUR_BLK_LOADER_SUM_EN to add the blk_sum accumulator.
module cur_blk_loader #(
    parameter int unsigned FRAME_W = 352,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       blk_x,
    input  logic [7:0]       blk_y,
    cur_blk_loader_if.master mem,
    output logic             rf_we,
    output logic [63:0]      rf_data,
    output logic             busy,
    output logic             done
`ifdef CUR_BLK_LOADER_SUM_EN
    ,
    output logic [15:0]      blk_sum
`endif
);

    localparam int unsigned WORDS_PER_ROW = FRAME_W / 8;
    localparam int unsigned N_WORDS       = 32;
    localparam int unsigned CNT_W         = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       x_q;
    logic [7:0]       y_q;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] rsp_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [63:0]      blk_buf [N_WORDS];

    logic             beat_ok_c;
    logic             enter_write_c;
    logic             load_word_c;
    logic [4:0]       load_idx_c;
    logic [63:0]      load_data_c;

    // Word address of request k: two words per block row, k/2 selects the row.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [7:0] x,
                                                    input logic [7:0] y,
                                                    input logic [4:0] k);
        logic [31:0] row;
        logic [31:0] addr;
        row  = 32'(y) * 32'd16 + 32'(k[4:1]);
        addr = row * 32'(WORDS_PER_ROW) + 32'(x) * 32'd2 + 32'(k[0]);
        return ADDR_W'(addr);
    endfunction

    // Beat acceptance and write-burst sequencing.
    always_comb begin
        beat_ok_c     = 1'b0;
        enter_write_c = 1'b0;
        load_word_c   = 1'b0;
        load_idx_c    = 5'd0;

        beat_ok_c = mem.mem_rd_valid && (state == FETCH || state == DRAIN) && !rsp_cnt[5];
        // All 32 beats in hand; FETCH can only take this path on its last grant.
        enter_write_c = (state == DRAIN && rsp_cnt[5]) ||
                        (state == FETCH && mem.mem_gnt && req_cnt == 6'd31 && rsp_cnt[5]);
        load_word_c   = enter_write_c || (state == WRITE && !wr_cnt[5]);
        load_idx_c    = enter_write_c ? 5'd0 : wr_cnt[4:0];
    end

    assign load_data_c = blk_buf[load_idx_c];

    // Response buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (beat_ok_c) begin
            blk_buf[rsp_cnt[4:0]] <= mem.mem_rd_data;
        end
    end

    // Loader FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            req_cnt      <= '0;
            rsp_cnt      <= '0;
            wr_cnt       <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            rf_we        <= 1'b0;
            rf_data      <= 64'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (beat_ok_c) begin
                rsp_cnt <= rsp_cnt + 6'd1;
            end
            // Every WRITE cycle (and the entry edge) presents the next buffered word.
            if (load_word_c) begin
                rf_we   <= 1'b1;
                rf_data <= load_data_c;
                wr_cnt  <= {1'b0, load_idx_c} + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        x_q          <= blk_x;
                        y_q          <= blk_y;
                        req_cnt      <= '0;
                        rsp_cnt      <= '0;
                        wr_cnt       <= '0;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= word_addr(blk_x, blk_y, 5'd0);
                        busy         <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    // Address advances only on a grant, so it holds through stalls.
                    if (mem.mem_gnt) begin
                        req_cnt <= req_cnt + 6'd1;
                        if (req_cnt == 6'd31) begin
                            mem.mem_req <= 1'b0;
                            state       <= enter_write_c ? WRITE : DRAIN;
                        end else begin
                            mem.mem_addr <= word_addr(x_q, y_q, 5'(req_cnt + 6'd1));
                        end
                    end
                end
                DRAIN: begin
                    if (enter_write_c) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_cnt[5]) begin
                        rf_we   <= 1'b0;
                        rf_data <= 64'd0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CUR_BLK_LOADER_SUM_EN
    function automatic logic [15:0] byte_sum(input logic [63:0] w);
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + 16'(w[i*8 +: 8]);
        end
        return s;
    endfunction

    // Pixel sum follows the words as they are written; cleared on a new start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_sum <= 16'd0;
        end else if (state == IDLE && start) begin
            blk_sum <= 16'd0;
        end else if (load_word_c) begin
            blk_sum <= blk_sum + byte_sum(load_data_c);
        end
    end
`endif

endmodule
